cnt_pulse_gen: RTL and testbench

//  Upstream stage of circuit_2. It turns a raw, asynchronous, bouncy event

---
 rtl/cnt_pulse_gen_if.sv | 40 ++++
 rtl/cnt_pulse_gen.sv | 163 ++++++++++++++++
 tb/tb_cnt_pulse_gen.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/cnt_pulse_gen_if.sv
// cnt_pulse_gen_if
//   Bundles the event-line inputs and the pulse/debug outputs of
//   cnt_pulse_gen. Clock and reset stay as plain ports on the block.
//
//   Handshake: there is no valid/ready pair. raw_in is a free-running,
//   asynchronous level. enable and clr are sampled on every rising clk
//   edge. cnt_out is a one-cycle strobe that the consumer must take in the
//   cycle it is high, because it cannot be back-pressured.
//
//   Signals:
//     raw_in        master->slave  raw asynchronous event line
//     enable        master->slave  1 = qualified rising edges produce pulses
//     clr           master->slave  synchronous clear of both counters
//     cnt_out       slave->master  one-cycle pulse
//     level         slave->master  debounced level
//     evt_count     slave->master  pulses emitted (saturating, CW bits)
//     glitch_count  slave->master  aborted qualifications (saturating, CW bits)
//     dbg_state     slave->master  debounce FSM state, for observation only
interface cnt_pulse_gen_if #(
  parameter int CW = 8
);
  logic          raw_in;
  logic          enable;
  logic          clr;
  logic          cnt_out;
  logic          level;
  logic [CW-1:0] evt_count;
  logic [CW-1:0] glitch_count;
  logic [1:0]    dbg_state;

  modport master (
    output raw_in, enable, clr,
    input  cnt_out, level, evt_count, glitch_count, dbg_state
  );

  modport slave (
    input  raw_in, enable, clr,
    output cnt_out, level, evt_count, glitch_count, dbg_state
  );
endinterface

// File: rtl/cnt_pulse_gen.sv
// cnt_pulse_gen
//   Turns a raw, asynchronous, bouncy event line into clean single-cycle
//   pulses for the CNT input of circuit_2. The line is synchronised, both
//   edges are debounced, and one pulse is emitted per qualified rising edge
//   while enable is high. Saturating event and glitch counters are kept for
//   debug.
//
//   Ports:
//     clk   in   system clock, rising edge
//     rst   in   asynchronous, active-high reset
//     bus   cnt_pulse_gen_if.slave: raw_in, enable, clr in;
//           cnt_out, level, evt_count, glitch_count, dbg_state out
//
//   Parameters:
//     SYNC_STAGES      synchroniser flops on raw_in (>= 2)
//     DEBOUNCE_CYCLES  consecutive equal synced samples to qualify an edge (>= 1)
//     CW               counter width (must match the interface CW)
module cnt_pulse_gen #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CW              = 8
) (
  input logic             clk,
  input logic             rst,
  cnt_pulse_gen_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    QUAL_HIGH = 2'd1,
    HIGH      = 2'd2,
    QUAL_LOW  = 2'd3
  } state_e;

  // dcnt only has to reach DEBOUNCE_CYCLES-1.
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DONE  = DW'(1);
  localparam logic [CW-1:0] CMAX  = {CW{1'b1}};
  localparam logic [CW-1:0] CONE  = CW'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_e                 state_q;
  logic [DW-1:0]          dcnt_q;
  logic                   cnt_out_q;
  logic [CW-1:0]          evt_count_q,    evt_count_d;
  logic [CW-1:0]          glitch_count_q, glitch_count_d;
  logic                   glitch_ev;

  // ---------------------------------------------------------------------
  // Synchroniser: s is raw_in delayed by SYNC_STAGES flops.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.raw_in};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------
  // Debounce FSM. cnt_out_q defaults low every cycle, so a pulse set on the
  // QUAL_HIGH->HIGH transition lasts exactly one cycle. HIGH never pulses,
  // so re-enabling while the line stays high produces nothing.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE_LOW;
      dcnt_q    <= '0;
      cnt_out_q <= 1'b0;
    end else begin
      cnt_out_q <= 1'b0;
      case (state_q)
        IDLE_LOW: begin
          if (s) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state_q   <= HIGH;
              cnt_out_q <= bus.enable;
            end else begin
              state_q <= QUAL_HIGH;
              dcnt_q  <= DONE;
            end
          end
        end
        QUAL_HIGH: begin
          if (!s) begin
            state_q <= IDLE_LOW;
          end else if (dcnt_q == DLAST) begin
            state_q   <= HIGH;
            cnt_out_q <= bus.enable;
          end else begin
            dcnt_q <= dcnt_q + DONE;
          end
        end
        HIGH: begin
          if (!s) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state_q <= IDLE_LOW;
            end else begin
              state_q <= QUAL_LOW;
              dcnt_q  <= DONE;
            end
          end
        end
        QUAL_LOW: begin
          if (s) begin
            state_q <= HIGH;
          end else if (dcnt_q == DLAST) begin
            state_q <= IDLE_LOW;
          end else begin
            dcnt_q <= dcnt_q + DONE;
          end
        end
        default: begin
          state_q <= IDLE_LOW;
        end
      endcase
    end
  end

  // A qualification aborted in either direction counts as a glitch.
  assign glitch_ev = ((state_q == QUAL_HIGH) && !s) ||
                     ((state_q == QUAL_LOW)  &&  s);

  // ---------------------------------------------------------------------
  // Saturating counters; clr wins over a simultaneous increment.
  // ---------------------------------------------------------------------
  always_comb begin
    evt_count_d    = evt_count_q;
    glitch_count_d = glitch_count_q;
    if (bus.clr) begin
      evt_count_d    = '0;
      glitch_count_d = '0;
    end else begin
      if (cnt_out_q && (evt_count_q != CMAX)) begin
        evt_count_d = evt_count_q + CONE;
      end
      if (glitch_ev && (glitch_count_q != CMAX)) begin
        glitch_count_d = glitch_count_q + CONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_count_q    <= '0;
      glitch_count_q <= '0;
    end else begin
      evt_count_q    <= evt_count_d;
      glitch_count_q <= glitch_count_d;
    end
  end

  assign bus.cnt_out      = cnt_out_q;
  assign bus.level        = (state_q == HIGH) || (state_q == QUAL_LOW);
  assign bus.evt_count    = evt_count_q;
  assign bus.glitch_count = glitch_count_q;
  assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_cnt_pulse_gen.sv
// tb_cnt_pulse_gen
//   Directed bench for cnt_pulse_gen. dut1 uses the default parameters;
//   dut2 uses CW=2 for the counter saturation and clear-priority cases.
//   Inputs change 1 time unit after a rising edge; outputs are sampled at
//   the same point, i.e. they reflect the edge just taken.
module tb_cnt_pulse_gen;

  logic clk;
  logic rst;

  int checks = 0;
  int errors = 0;

  cnt_pulse_gen_if #(.CW(8)) if1 ();
  cnt_pulse_gen_if #(.CW(2)) if2 ();

  cnt_pulse_gen #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .CW(8)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  cnt_pulse_gen #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .CW(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (if2)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic glitch2(input logic clr_on_abort);
    // raw high for 2 edges; the abort lands on relative edge 5.
    if2.raw_in = 1'b1; tick(); tick();
    if2.raw_in = 1'b0; tick(); tick();
    if2.clr = clr_on_abort; tick();
    if2.clr = 1'b0; tick(); tick(); tick();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic raw;
    logic en;
    logic clr;
    logic exp_cnt;
    logic exp_level;
  } vec_t;

  localparam int NV = 32;
  vec_t vecs[NV];

  // circuit_2 model: counts cycles with CNT high, modulo 3; PO = (count==2).
  int   c2_count;
  logic c2_po;
  logic exp_po[3];

  initial begin
    int   pulses;
    logic prev;

    // Records 0..13: raw high 12 edges then low -> pulse after edge 6 only.
    // Records 14..19: line stays low, debounced low after edge 18.
    // Records 20..31: 3-edge blip -> glitch, no pulse, level stays 0.
    for (int j = 0; j < NV; j++) begin
      vecs[j].raw       = (j < 12) || (j >= 20 && j < 23);
      vecs[j].en        = 1'b1;
      vecs[j].clr       = 1'b0;
      vecs[j].exp_cnt   = (j == 5);
      vecs[j].exp_level = (j >= 5) && (j < 17);
    end
    exp_po[0] = 1'b0;
    exp_po[1] = 1'b1;
    exp_po[2] = 1'b0;

    // ---------------- reset ----------------
    rst = 1'b1;
    if1.raw_in = 1'b0; if1.enable = 1'b1; if1.clr = 1'b0;
    if2.raw_in = 1'b0; if2.enable = 1'b1; if2.clr = 1'b0;
    tick(); tick(); tick();
    check("rst_cnt_out", 32'(if1.cnt_out), 0);
    check("rst_level",   32'(if1.level), 0);
    check("rst_evt",     32'(if1.evt_count), 0);
    check("rst_glitch",  32'(if1.glitch_count), 0);
    check("rst_state",   32'(if1.dbg_state), 0);
    rst = 1'b0;

    // ---------------- tests 1 and 2: table ----------------
    for (int j = 0; j < NV; j++) begin
      if1.raw_in = vecs[j].raw;
      if1.enable = vecs[j].en;
      if1.clr    = vecs[j].clr;
      tick();
      check($sformatf("vec%0d_cnt_out", j), 32'(if1.cnt_out), 32'(vecs[j].exp_cnt));
      check($sformatf("vec%0d_level", j),   32'(if1.level),   32'(vecs[j].exp_level));
    end
    check("t12_evt",    32'(if1.evt_count), 1);
    check("t12_glitch", 32'(if1.glitch_count), 1);

    // ---------------- clr ----------------
    if1.clr = 1'b1; tick(); if1.clr = 1'b0;
    check("clr_evt",    32'(if1.evt_count), 0);
    check("clr_glitch", 32'(if1.glitch_count), 0);

    // ---------------- test 3: three clean pulses into circuit_2 ----------------
    c2_count = 0;
    c2_po    = 1'b0;
    prev     = 1'b0;
    for (int p = 0; p < 3; p++) begin
      pulses = 0;
      for (int c = 0; c < 20; c++) begin
        if1.raw_in = (c < 10);
        tick();
        if (if1.cnt_out) begin
          pulses++;
          check("t3_no_back_to_back", 32'(prev), 0);
          c2_count = (c2_count + 1) % 3;
          c2_po    = (c2_count == 2);
        end
        prev = if1.cnt_out;
      end
      check($sformatf("t3_pulses_%0d", p), 32'(pulses), 1);
      check($sformatf("t3_po_%0d", p), 32'(c2_po), 32'(exp_po[p]));
    end
    check("t3_evt", 32'(if1.evt_count), 3);

    // ---------------- test 4: edge consumed while disabled ----------------
    if1.clr = 1'b1; tick(); if1.clr = 1'b0;
    if1.enable = 1'b0;
    if1.raw_in = 1'b1;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (if1.cnt_out) pulses++;
    end
    check("t4_level_dis", 32'(if1.level), 1);
    check("t4_state_high", 32'(if1.dbg_state), 2);
    if1.enable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (if1.cnt_out) pulses++;
    end
    check("t4_pulses", 32'(pulses), 0);
    check("t4_evt",    32'(if1.evt_count), 0);
    check("t4_level",  32'(if1.level), 1);
    if1.raw_in = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    check("t4_level_low", 32'(if1.level), 0);

    // ---------------- test 5: reset mid-qualification ----------------
    if1.raw_in = 1'b1;
    tick(); tick(); tick(); tick();
    check("t5_state_qual", 32'(if1.dbg_state), 1);
    #2 rst = 1'b1;
    #1;
    check("t5_async_state", 32'(if1.dbg_state), 0);
    check("t5_async_cnt",   32'(if1.cnt_out), 0);
    check("t5_async_level", 32'(if1.level), 0);
    tick();
    check("t5_hold_state", 32'(if1.dbg_state), 0);
    check("t5_hold_evt",   32'(if1.evt_count), 0);
    rst = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      check($sformatf("t5_edge%0d_cnt", k), 32'(if1.cnt_out), 32'(k == 6));
    end
    check("t5_evt", 32'(if1.evt_count), 1);
    if1.raw_in = 1'b0;
    for (int c = 0; c < 10; c++) tick();

    // ---------------- test 6: CW=2 saturation and clr priority ----------------
    for (int g = 0; g < 5; g++) begin
      glitch2(1'b0);
      check($sformatf("t6_glitch_%0d", g), 32'(if2.glitch_count), (g < 3) ? g + 1 : 3);
    end
    glitch2(1'b1);
    check("t6_clr_sat", 32'(if2.glitch_count), 0);
    glitch2(1'b0);
    check("t6_after_clr", 32'(if2.glitch_count), 1);
    glitch2(1'b1);
    check("t6_clr_wins", 32'(if2.glitch_count), 0);
    check("t6_level", 32'(if2.level), 0);
    check("t6_evt",   32'(if2.evt_count), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
